// File: rtl/exc_req_gen_pkg.sv
// Shared definitions for the CP0 exception request generator:
// cause codes, STATUS bit positions, FSM and source encodings.
package exc_req_gen_pkg;

    localparam logic [4:0] CAUSE_INT     = 5'b00000;
    localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
    localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

    localparam int unsigned ST_IE      = 0;
    localparam int unsigned ST_SYSCALL = 1;
    localparam int unsigned ST_BREAK   = 2;
    localparam int unsigned ST_TEQ     = 3;
    localparam int unsigned ST_EXT     = 4;
    localparam int unsigned ST_TIMER   = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SRC_NONE    = 3'd0,
        SRC_SYSCALL = 3'd1,
        SRC_BREAK   = 3'd2,
        SRC_TEQ     = 3'd3,
        SRC_EXT     = 3'd4,
        SRC_TIMER   = 3'd5
    } src_t;

    function automatic logic [4:0] cause_of(src_t src);
        logic [4:0] code;
        code = CAUSE_INT;
        case (src)
            SRC_SYSCALL: code = CAUSE_SYSCALL;
            SRC_BREAK:   code = CAUSE_BREAK;
            SRC_TEQ:     code = CAUSE_TEQ;
            default:     code = CAUSE_INT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/exc_req_gen_if.sv
// Signal bundle between the trap/interrupt sources, CP0 and exc_req_gen.
// master is the request generator's view, slave the surrounding core's view.
interface exc_req_gen_if #(
    parameter int unsigned CNT_W = 32
);
    logic             syscall;
    logic             brk;
    logic             teq_trap;
    logic             ext_int;
    logic [31:0]      status;
    logic             eret;
    logic             cmp_we;
    logic [CNT_W-1:0] cmp_data;
    logic             exception;
    logic [4:0]       cause;
    logic             timer_int;
    logic             in_service;
    logic             overrun;
    logic [CNT_W-1:0] count;

    modport master (
        input  syscall, brk, teq_trap, ext_int, status, eret, cmp_we, cmp_data,
        output exception, cause, timer_int, in_service, overrun, count
    );

    modport slave (
        output syscall, brk, teq_trap, ext_int, status, eret, cmp_we, cmp_data,
        input  exception, cause, timer_int, in_service, overrun, count
    );
endinterface

// File: rtl/exc_req_gen_timer.sv
// COUNT/COMPARE timer: prescaled free-running counter with a sticky
// match flag that only a COMPARE write clears.
module exc_timer #(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmp_we,
    input  logic [CNT_W-1:0] cmp_data,
    output logic [CNT_W-1:0] count,
    output logic             timer_int
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  presc;
    logic [CNT_W-1:0] compare;
    logic [CNT_W-1:0] count_nxt;
    logic             tick;

    assign tick      = (presc == PS_LAST);
    assign count_nxt = count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            count     <= '0;
            compare   <= '1;
            timer_int <= 1'b0;
        end else begin
            if (tick) begin
                presc <= '0;
                count <= count_nxt;
            end else begin
                presc <= presc + PS_W'(1);
            end
            // Match is taken on the value COUNT is about to take, so the flag
            // rises together with COUNT reaching COMPARE; a write always wins.
            if (cmp_we) begin
                compare   <= cmp_data;
                timer_int <= 1'b0;
            end else if (tick && (count_nxt == compare)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_req_gen.sv
// Exception/interrupt request generator feeding CP0: masks sources with
// STATUS, picks one by fixed priority and holds off until ERET.
module exc_req_gen
    import exc_req_gen_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned CNT_W    = 32
) (
    input logic           clk,
    input logic           rst_n,
    exc_req_gen_if.master bus
);

    state_t     state;
    src_t       src;
    logic [1:0] ext_sync;
    logic       ext_last;
    logic       ext_rise;
    logic       ext_pend;
    logic       timer_int;
    logic       ie;
    logic       en_sys;
    logic       en_brk;
    logic       en_teq;
    logic       en_ext;
    logic       en_tmr;
    logic       sync_drop;
    logic       exception;
    logic [4:0] cause;
    logic       in_service;
    logic       overrun;
    logic       unused_status;

    exc_timer #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmp_we    (bus.cmp_we),
        .cmp_data  (bus.cmp_data),
        .count     (bus.count),
        .timer_int (timer_int)
    );

    assign unused_status = ^bus.status[31:6];

    assign ext_rise = ext_sync[1] & ~ext_last;

    assign ie     = bus.status[ST_IE];
    assign en_sys = ie & bus.status[ST_SYSCALL] & bus.syscall;
    assign en_brk = ie & bus.status[ST_BREAK]   & bus.brk;
    assign en_teq = ie & bus.status[ST_TEQ]     & bus.teq_trap;
    assign en_ext = ie & bus.status[ST_EXT]     & ext_pend;
    assign en_tmr = ie & bus.status[ST_TIMER]   & timer_int;

    always_comb begin
        src = SRC_NONE;
        if (en_sys)      src = SRC_SYSCALL;
        else if (en_brk) src = SRC_BREAK;
        else if (en_teq) src = SRC_TEQ;
        else if (en_ext) src = SRC_EXT;
        else if (en_tmr) src = SRC_TIMER;
    end

    // Enabled trap pulses that cannot be issued are lost: the losers of a
    // same-cycle tie in IDLE, or any arrival while a request is outstanding.
    always_comb begin
        if (state == IDLE) begin
            sync_drop = (en_sys & (en_brk | en_teq)) | (en_brk & en_teq);
        end else begin
            sync_drop = en_sys | en_brk | en_teq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync   <= '0;
            ext_last   <= 1'b0;
            ext_pend   <= 1'b0;
            state      <= IDLE;
            exception  <= 1'b0;
            cause      <= '0;
            in_service <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            ext_sync  <= {ext_sync[0], bus.ext_int};
            ext_last  <= ext_sync[1];
            exception <= 1'b0;

            // A fresh edge in the issuing cycle re-arms the pending flag.
            if ((state == IDLE) && (src == SRC_EXT)) ext_pend <= 1'b0;
            if (ext_rise)                           ext_pend <= 1'b1;

            if (sync_drop) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (src != SRC_NONE) begin
                        state     <= ISSUE;
                        exception <= 1'b1;
                        cause     <= cause_of(src);
                    end
                end
                ISSUE: begin
                    state      <= SERVICE;
                    in_service <= 1'b1;
                end
                SERVICE: begin
                    if (bus.eret) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

    assign bus.exception  = exception;
    assign bus.cause      = cause;
    assign bus.in_service = in_service;
    assign bus.overrun    = overrun;
    assign bus.timer_int  = timer_int;

endmodule

// File: tb/tb_exc_req_gen.sv
// Directed bench for exc_req_gen: a vector table for the trap/FSM flow plus
// hand sequences for the external interrupt, timer and mid-request reset.
module tb_exc_req_gen;

    localparam int unsigned CNT_W = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    exc_req_gen_if #(.CNT_W(CNT_W)) bus ();

    exc_req_gen #(
        .PRESCALE (1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] status;
        logic        sys;
        logic        brk;
        logic        teq;
        logic        eret;
        logic        exc;
        logic [4:0]  cause;
        logic        ins;
        logic        ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [31:0] status, logic sys, logic brk,
                                logic teq, logic eret, logic exc, logic [4:0] cause,
                                logic ins, logic ov);
        vec_t v;
        v.rst = rst; v.status = status; v.sys = sys; v.brk = brk; v.teq = teq;
        v.eret = eret; v.exc = exc; v.cause = cause; v.ins = ins; v.ov = ov;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.syscall  = 1'b0;
        bus.brk      = 1'b0;
        bus.teq_trap = 1'b0;
        bus.eret     = 1'b0;
        bus.cmp_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bit seen;
        int lat;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear_inputs();
        bus.ext_int  = 1'b0;
        bus.status   = 32'h3F;
        bus.cmp_data = '0;

        @(negedge clk);
        check("rst_exception", bus.exception, 1'b0);
        check("rst_cause", bus.cause, 5'b0);
        check("rst_in_service", bus.in_service, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        check("rst_timer_int", bus.timer_int, 1'b0);
        check("rst_count", bus.count, 32'd0);
        rst_n = 1'b1;

        //            rst status  sys brk teq eret | exc cause     ins ov
        tbl.push_back(mk(1, 32'h3F, 0, 0, 0, 0,   0, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 32'h3F, 0, 0, 0, 0,   0, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 32'h3F, 1, 0, 0, 0,   1, 5'b01000, 0, 0));
        tbl.push_back(mk(0, 32'h3F, 0, 0, 0, 0,   0, 5'b00000, 1, 0));
        tbl.push_back(mk(0, 32'h3F, 0, 0, 0, 0,   0, 5'b00000, 1, 0));
        tbl.push_back(mk(0, 32'h3F, 0, 0, 0, 1,   0, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 32'h3F, 0, 0, 0, 1,   0, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 32'h3F, 1, 0, 1, 0,   1, 5'b01000, 0, 1));
        tbl.push_back(mk(0, 32'h3F, 0, 0, 0, 0,   0, 5'b00000, 1, 1));
        tbl.push_back(mk(0, 32'h3F, 0, 1, 0, 0,   0, 5'b00000, 1, 1));
        tbl.push_back(mk(0, 32'h3F, 0, 0, 0, 1,   0, 5'b00000, 0, 1));
        tbl.push_back(mk(0, 32'h3F, 0, 0, 0, 0,   0, 5'b00000, 0, 1));
        tbl.push_back(mk(1, 32'h3F, 0, 0, 0, 0,   0, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 32'h3E, 1, 0, 0, 0,   0, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 32'h3D, 1, 1, 0, 0,   1, 5'b01001, 0, 0));
        tbl.push_back(mk(0, 32'h3D, 0, 0, 0, 1,   0, 5'b00000, 1, 0));
        tbl.push_back(mk(0, 32'h3D, 0, 0, 0, 0,   0, 5'b00000, 1, 0));
        tbl.push_back(mk(0, 32'h3D, 0, 0, 1, 0,   0, 5'b00000, 1, 1));
        tbl.push_back(mk(0, 32'h3D, 0, 0, 0, 1,   0, 5'b00000, 0, 1));
        tbl.push_back(mk(1, 32'h3F, 0, 0, 0, 0,   0, 5'b00000, 0, 0));
        tbl.push_back(mk(0, 32'h3F, 0, 0, 1, 0,   1, 5'b01101, 0, 0));
        tbl.push_back(mk(0, 32'h3F, 1, 0, 0, 0,   0, 5'b00000, 1, 1));
        tbl.push_back(mk(0, 32'h3F, 1, 0, 0, 1,   0, 5'b00000, 0, 1));
        tbl.push_back(mk(0, 32'h3F, 0, 0, 0, 0,   0, 5'b00000, 0, 1));

        foreach (tbl[i]) begin
            rst_n        = ~tbl[i].rst;
            bus.status   = tbl[i].status;
            bus.syscall  = tbl[i].sys;
            bus.brk      = tbl[i].brk;
            bus.teq_trap = tbl[i].teq;
            bus.eret     = tbl[i].eret;
            step();
            check($sformatf("vec%0d_exception", i), bus.exception, tbl[i].exc);
            check($sformatf("vec%0d_in_service", i), bus.in_service, tbl[i].ins);
            check($sformatf("vec%0d_overrun", i), bus.overrun, tbl[i].ov);
            check($sformatf("vec%0d_timer_int", i), bus.timer_int, 1'b0);
            if (tbl[i].exc) check($sformatf("vec%0d_cause", i), bus.cause, tbl[i].cause);
            if (tbl[i].rst) check($sformatf("vec%0d_rst_count", i), bus.count, 32'd0);
        end
        rst_n = 1'b1;
        clear_inputs();

        // External interrupt: held while masked, issued once enabled.
        do_reset();
        bus.status  = 32'h2F;
        bus.ext_int = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.exception) seen = 1'b1;
        end
        check("ext_masked_no_req", seen, 1'b0);
        bus.status = 32'h3F;
        lat = 0;
        for (int i = 0; i < 4 && !bus.exception; i++) begin
            step();
            lat++;
        end
        check("ext_req_issued", bus.exception, 1'b1);
        check("ext_req_cause", bus.cause, 5'b00000);
        check("ext_req_latency", lat, 1);
        step();
        check("ext_in_service", bus.in_service, 1'b1);
        bus.eret = 1'b1;
        step();
        bus.eret = 1'b0;
        check("ext_eret", bus.in_service, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.exception) seen = 1'b1;
        end
        check("ext_level_no_refire", seen, 1'b0);
        bus.ext_int = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.ext_int = 1'b1;
        lat = 0;
        for (int i = 0; i < 6 && !bus.exception; i++) begin
            step();
            lat++;
        end
        check("ext_new_edge_req", bus.exception, 1'b1);
        check("ext_new_edge_latency", lat, 4);
        bus.ext_int = 1'b0;
        step();
        bus.eret = 1'b1;
        step();
        bus.eret = 1'b0;

        // Timer: COMPARE=5 loaded while COUNT=0.
        rst_n        = 1'b0;
        bus.status   = 32'h3F;
        bus.cmp_we   = 1'b1;
        bus.cmp_data = 32'd5;
        step();
        rst_n = 1'b1;
        step();
        bus.cmp_we = 1'b0;
        check("tmr_count_1", bus.count, 32'd1);
        check("tmr_int_low", bus.timer_int, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("tmr_count_4", bus.count, 32'd4);
        check("tmr_int_before", bus.timer_int, 1'b0);
        step();
        check("tmr_count_5", bus.count, 32'd5);
        check("tmr_int_set", bus.timer_int, 1'b1);
        check("tmr_no_req_yet", bus.exception, 1'b0);
        step();
        check("tmr_req1", bus.exception, 1'b1);
        check("tmr_req1_cause", bus.cause, 5'b00000);
        step();
        check("tmr_service1", bus.in_service, 1'b1);
        bus.eret = 1'b1;
        step();
        bus.eret = 1'b0;
        check("tmr_eret1", bus.in_service, 1'b0);
        check("tmr_int_held", bus.timer_int, 1'b1);
        step();
        check("tmr_req2", bus.exception, 1'b1);
        check("tmr_req2_count", bus.count, 32'd9);
        step();
        bus.cmp_we   = 1'b1;
        bus.cmp_data = '1;
        step();
        bus.cmp_we = 1'b0;
        check("tmr_cmp_clear", bus.timer_int, 1'b0);
        bus.eret = 1'b1;
        step();
        bus.eret = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.exception) seen = 1'b1;
        end
        check("tmr_no_refire", seen, 1'b0);

        // Asynchronous reset while a request is on EXCEPTION.
        bus.syscall = 1'b1;
        step();
        bus.syscall = 1'b0;
        check("arst_pre_req", bus.exception, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_exception", bus.exception, 1'b0);
        check("arst_count", bus.count, 32'd0);
        check("arst_in_service", bus.in_service, 1'b0);
        check("arst_compare", dut.u_timer.compare, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_idle_after", bus.exception, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
